// File: rtl/bit_unstuff.sv
// Receive-path bit de-stuffer: drops the zero inserted after six ones, flags a
// seventh consecutive one, and packs surviving bits LSB-first into bytes.
module bit_unstuff (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       rx_active,
  input  logic       bit_valid,
  input  logic       data_in,
  input  logic       eop,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       stuff_err,
  output logic       rx_done,
  output logic       align_err
);

  // state  | meaning
  // IDLE   | waiting for a fresh rising edge of rx_active
  // RECV   | de-stuffing and packing bits of the current packet
  // ERROR  | seven ones seen; packet ignored until rx_active falls
  // DONE   | EOP seen; packet ignored until rx_active falls
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_ERROR = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] ones_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       rx_active_q;
  logic [7:0] shreg_next;

  assign shreg_next = {data_in, shreg[7:1]};

  // rx_active_q resets high so a packet already in flight when reset is
  // released is skipped; reception restarts only on a genuine rising edge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= S_IDLE;
      ones_cnt    <= 3'd0;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      rx_active_q <= 1'b1;
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      stuff_err   <= 1'b0;
      rx_done     <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      rx_active_q <= rx_active;
      data_valid  <= 1'b0;
      rx_done     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (rx_active && !rx_active_q) begin
            state    <= S_RECV;
            bit_cnt  <= 3'd0;
            ones_cnt <= 3'd1;
            shreg    <= 8'h00;
          end
        end

        S_RECV: begin
          if (!rx_active) begin
            state     <= S_IDLE;
            stuff_err <= 1'b0;
            align_err <= 1'b0;
          end else if (eop) begin
            state     <= S_DONE;
            rx_done   <= 1'b1;
            align_err <= (bit_cnt != 3'd0);
          end else if (bit_valid) begin
            if (ones_cnt == 3'd6) begin
              if (!data_in) begin
                ones_cnt <= 3'd0;
              end else begin
                state     <= S_ERROR;
                stuff_err <= 1'b1;
                bit_cnt   <= 3'd0;
                shreg     <= 8'h00;
              end
            end else begin
              shreg    <= shreg_next;
              ones_cnt <= data_in ? 3'(ones_cnt + 3'd1) : 3'd0;
              bit_cnt  <= 3'(bit_cnt + 3'd1);
              if (bit_cnt == 3'd7) begin
                data_out   <= shreg_next;
                data_valid <= 1'b1;
              end
            end
          end
        end

        S_ERROR: begin
          if (!rx_active) begin
            state     <= S_IDLE;
            stuff_err <= 1'b0;
            align_err <= 1'b0;
          end
        end

        S_DONE: begin
          if (!rx_active) begin
            state     <= S_IDLE;
            stuff_err <= 1'b0;
            align_err <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_unstuff.sv
// Self-checking bench for bit_unstuff: directed scenarios plus randomized
// packets checked against a queue-based de-stuffing reference model.
module tb_bit_unstuff;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       rx_active = 1'b0;
  logic       bit_valid = 1'b0;
  logic       data_in = 1'b0;
  logic       eop = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, stuff_err, rx_done, align_err;

  int tests = 0;
  int failed = 0;

  bit         tx_bits[$];
  logic [7:0] tx_bytes[$];
  logic [7:0] exp_bytes[$];
  int         exp_idx[$];
  bit         exp_done, exp_align, exp_stuff;

  // observation log, written only by the monitor
  logic [7:0] got_bytes[$];
  int         got_cyc[$];
  int         got_done = 0;
  logic       got_align = 1'b0;
  int         got_stuff_cnt = 0;
  int         cyc = 0;

  bit_unstuff dut (
    .Clk(Clk), .Rst(Rst), .rx_active(rx_active), .bit_valid(bit_valid),
    .data_in(data_in), .eop(eop), .data_out(data_out), .data_valid(data_valid),
    .stuff_err(stuff_err), .rx_done(rx_done), .align_err(align_err)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    cyc <= cyc + 1;
    if (data_valid) begin
      got_bytes.push_back(data_out);
      got_cyc.push_back(cyc);
    end
    if (rx_done) begin
      got_done  <= got_done + 1;
      got_align <= align_err;
    end
    if (stuff_err) got_stuff_cnt <= got_stuff_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // transmit-side stuffing: a zero goes in after every run of six ones,
  // with the final SYNC one counting toward the first run
  task automatic encode();
    int ones;
    ones = 1;
    tx_bits.delete();
    foreach (tx_bytes[k]) begin
      for (int j = 0; j < 8; j++) begin
        tx_bits.push_back(tx_bytes[k][j]);
        ones = tx_bytes[k][j] ? ones + 1 : 0;
        if (ones == 6) begin
          tx_bits.push_back(1'b0);
          ones = 0;
        end
      end
    end
  endtask

  // mode 0: no eop, 1: eop after last bit, 2: eop together with last bit
  task automatic model(input int mode);
    int ones;
    bit acc[$];
    logic [7:0] v;
    int n;
    ones = 1;
    n = tx_bits.size();
    exp_bytes.delete();
    exp_idx.delete();
    exp_stuff = 0;
    for (int i = 0; i < n; i++) begin
      if (mode == 2 && i == n - 1) break;
      if (ones == 6) begin
        if (tx_bits[i]) begin
          exp_stuff = 1;
          break;
        end
        ones = 0;
        continue;
      end
      acc.push_back(tx_bits[i]);
      ones = tx_bits[i] ? ones + 1 : 0;
      if (acc.size() % 8 == 0) begin
        for (int j = 0; j < 8; j++) v[j] = acc[acc.size() - 8 + j];
        exp_bytes.push_back(v);
        exp_idx.push_back(i);
      end
    end
    exp_done  = (mode != 0) && !exp_stuff;
    exp_align = exp_done && (acc.size() % 8 != 0);
  endtask

  task automatic run_packet(input int mode, input bit gaps, input bit hold);
    @(negedge Clk);
    rx_active = 1'b1;
    bit_valid = 1'b0;
    eop = 1'b0;
    @(negedge Clk);
    foreach (tx_bits[i]) begin
      bit_valid = 1'b1;
      data_in   = tx_bits[i];
      eop       = (mode == 2) && (i == tx_bits.size() - 1);
      @(negedge Clk);
      bit_valid = 1'b0;
      eop = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge Clk);
    end
    if (mode == 1) begin
      eop = 1'b1;
      @(negedge Clk);
      eop = 1'b0;
    end
    repeat (2) @(negedge Clk);
    if (!hold) begin
      rx_active = 1'b0;
      repeat (2) @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    tests++;
    if (data_out !== 8'h00 || data_valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_data: data_out=%h data_valid=%b, want 00/0", data_out, data_valid);
    end
    tests++;
    if (stuff_err !== 1'b0 || rx_done !== 1'b0 || align_err !== 1'b0) begin
      failed++;
      $display("FAIL reset_flags: stuff_err=%b rx_done=%b align_err=%b, want 0/0/0",
               stuff_err, rx_done, align_err);
    end
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_basic();
    int b0, d0, s0;
    tx_bytes = '{8'hA5, 8'h3C};
    encode();
    b0 = got_bytes.size(); d0 = got_done; s0 = got_stuff_cnt;
    run_packet(1, 0, 0);
    tests++;
    if (got_bytes.size() - b0 != 2 || got_bytes[b0] !== 8'hA5 || got_bytes[b0+1] !== 8'h3C) begin
      failed++;
      $display("FAIL basic_bytes: got %0d bytes %p, want A5 3C", got_bytes.size() - b0, got_bytes);
    end
    tests++;
    if (got_done - d0 != 1 || got_align !== 1'b0 || got_stuff_cnt != s0) begin
      failed++;
      $display("FAIL basic_end: rx_done=%0d align=%b stuff_cycles=%0d, want 1/0/0",
               got_done - d0, got_align, got_stuff_cnt - s0);
    end
  endtask

  task automatic test_stuffing();
    int b0, d0, s0;
    tx_bytes = '{8'hFF, 8'h00};
    encode();
    b0 = got_bytes.size(); d0 = got_done; s0 = got_stuff_cnt;
    run_packet(1, 1, 0);
    tests++;
    if (got_bytes.size() - b0 != 2 || got_bytes[b0] !== 8'hFF || got_bytes[b0+1] !== 8'h00) begin
      failed++;
      $display("FAIL stuff_bytes: got %0d bytes %p, want FF 00", got_bytes.size() - b0, got_bytes);
    end
    tests++;
    if (got_done - d0 != 1 || got_align !== 1'b0 || got_stuff_cnt != s0) begin
      failed++;
      $display("FAIL stuff_end: rx_done=%0d align=%b stuff_cycles=%0d, want 1/0/0",
               got_done - d0, got_align, got_stuff_cnt - s0);
    end
  endtask

  task automatic test_stuff_error();
    int b0, d0;
    tx_bits = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0};
    b0 = got_bytes.size(); d0 = got_done;
    run_packet(1, 0, 1);
    tests++;
    if (stuff_err !== 1'b1) begin
      failed++;
      $display("FAIL stuff_err_set: stuff_err=%b, want 1", stuff_err);
    end
    tests++;
    if (got_bytes.size() != b0 || got_done != d0) begin
      failed++;
      $display("FAIL stuff_err_quiet: data_valid=%0d rx_done=%0d, want 0/0",
               got_bytes.size() - b0, got_done - d0);
    end
    rx_active = 1'b0;
    @(negedge Clk);
    tests++;
    if (stuff_err !== 1'b0) begin
      failed++;
      $display("FAIL stuff_err_clear: stuff_err=%b one cycle after exit, want 0", stuff_err);
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_align();
    int b0, d0;
    tx_bits = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 0};
    b0 = got_bytes.size(); d0 = got_done;
    run_packet(1, 0, 1);
    tests++;
    if (got_bytes.size() - b0 != 1 || got_bytes[b0] !== 8'hA5) begin
      failed++;
      $display("FAIL align_bytes: got %0d bytes %p, want one A5", got_bytes.size() - b0, got_bytes);
    end
    tests++;
    if (got_done - d0 != 1 || got_align !== 1'b1 || align_err !== 1'b1 || data_out !== 8'hA5) begin
      failed++;
      $display("FAIL align_end: rx_done=%0d align@done=%b align_now=%b data_out=%h, want 1/1/1/A5",
               got_done - d0, got_align, align_err, data_out);
    end
    rx_active = 1'b0;
    @(negedge Clk);
    tests++;
    if (align_err !== 1'b0 || data_out !== 8'hA5) begin
      failed++;
      $display("FAIL align_clear: align_err=%b data_out=%h after exit, want 0/A5", align_err, data_out);
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_eop_collision();
    int b0, d0;
    tx_bits = '{1, 1, 0, 0, 1, 1, 0, 0};
    b0 = got_bytes.size(); d0 = got_done;
    run_packet(2, 0, 0);
    tests++;
    if (got_bytes.size() != b0) begin
      failed++;
      $display("FAIL eop_collision_dv: got %0d data_valid pulses, want 0", got_bytes.size() - b0);
    end
    tests++;
    if (got_done - d0 != 1 || got_align !== 1'b1) begin
      failed++;
      $display("FAIL eop_collision_end: rx_done=%0d align=%b, want 1/1", got_done - d0, got_align);
    end
  endtask

  task automatic test_reset_mid();
    int b0;
    tx_bits = '{0, 0, 1, 1, 1, 1, 0, 1};
    @(negedge Clk);
    rx_active = 1'b1;
    @(negedge Clk);
    foreach (tx_bits[i]) begin
      bit_valid = 1'b1;
      data_in = tx_bits[i];
      if (i != tx_bits.size() - 1) @(negedge Clk);
    end
    @(posedge Clk);
    #2;
    bit_valid = 1'b0;
    tests++;
    if (data_valid !== 1'b1 || data_out !== 8'hBC) begin
      failed++;
      $display("FAIL reset_mid_pre: data_valid=%b data_out=%h, want 1/BC", data_valid, data_out);
    end
    Rst = 1'b1;
    #1;
    tests++;
    if (data_valid !== 1'b0 || data_out !== 8'h00 || stuff_err !== 1'b0 ||
        rx_done !== 1'b0 || align_err !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_async: dv=%b data_out=%h se=%b done=%b ae=%b, want all 0",
               data_valid, data_out, stuff_err, rx_done, align_err);
    end
    @(negedge Clk);
    Rst = 1'b0;
    b0 = got_bytes.size();
    for (int i = 0; i < 16; i++) begin
      bit_valid = 1'b1;
      data_in = i[0];
      @(negedge Clk);
    end
    bit_valid = 1'b0;
    eop = 1'b1;
    @(negedge Clk);
    eop = 1'b0;
    @(negedge Clk);
    tests++;
    if (got_bytes.size() != b0 || rx_done !== 1'b0 || data_out !== 8'h00) begin
      failed++;
      $display("FAIL reset_mid_idle: %0d bytes, data_out=%h while rx_active held, want 0/00",
               got_bytes.size() - b0, data_out);
    end
    rx_active = 1'b0;
    repeat (2) @(negedge Clk);
    tx_bytes = '{8'h3C};
    encode();
    b0 = got_bytes.size();
    run_packet(1, 0, 0);
    tests++;
    if (got_bytes.size() - b0 != 1 || got_bytes[b0] !== 8'h3C) begin
      failed++;
      $display("FAIL reset_mid_next: got %0d bytes %p, want one 3C", got_bytes.size() - b0, got_bytes);
    end
  endtask

  task automatic test_back_to_back();
    int b0, bad;
    tx_bytes = '{8'hFF, 8'($urandom), 8'hFF, 8'hFE, 8'($urandom), 8'h7F};
    encode();
    model(1);
    b0 = got_bytes.size();
    run_packet(1, 0, 0);
    tests++;
    bad = (got_bytes.size() - b0 != exp_bytes.size()) ? 1 : 0;
    for (int k = 0; k < exp_bytes.size() && bad == 0; k++)
      if (got_bytes[b0+k] !== exp_bytes[k]) bad = 1;
    if (bad != 0) begin
      failed++;
      $display("FAIL b2b_bytes: got %p, want %p", got_bytes[b0:$], exp_bytes);
    end
    tests++;
    bad = 0;
    for (int k = 1; k < exp_bytes.size() && k < got_bytes.size() - b0; k++)
      if (got_cyc[b0+k] - got_cyc[b0+k-1] != exp_idx[k] - exp_idx[k-1]) bad = k;
    if (bad != 0) begin
      failed++;
      $display("FAIL b2b_spacing: byte %0d gap %0d cycles, want %0d", bad,
               got_cyc[b0+bad] - got_cyc[b0+bad-1], exp_idx[bad] - exp_idx[bad-1]);
    end
  endtask

  task automatic test_random();
    int b0, d0, s0, mode, len, bad;
    bit heavy;
    for (int p = 0; p < 30; p++) begin
      mode  = $urandom_range(0, 2);
      len   = $urandom_range(1, 40);
      heavy = $urandom_range(0, 1);
      tx_bits.delete();
      for (int i = 0; i < len; i++)
        tx_bits.push_back(heavy ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) != 0));
      model(mode);
      b0 = got_bytes.size(); d0 = got_done; s0 = got_stuff_cnt;
      run_packet(mode, $urandom_range(0, 1), 0);
      tests++;
      bad = (got_bytes.size() - b0 != exp_bytes.size()) ? 1 : 0;
      for (int k = 0; k < exp_bytes.size() && bad == 0; k++)
        if (got_bytes[b0+k] !== exp_bytes[k]) bad = 1;
      if (bad != 0) begin
        failed++;
        $display("FAIL rand_bytes pkt %0d: got %0d bytes, want %0d (%p)", p,
                 got_bytes.size() - b0, exp_bytes.size(), exp_bytes);
      end
      tests++;
      if ((got_done - d0) != int'(exp_done) || (got_stuff_cnt > s0) != exp_stuff) begin
        failed++;
        $display("FAIL rand_flags pkt %0d: rx_done=%0d stuff=%b, want %0d/%b", p,
                 got_done - d0, got_stuff_cnt > s0, exp_done, exp_stuff);
      end
      if (exp_done) begin
        tests++;
        if (got_align !== exp_align) begin
          failed++;
          $display("FAIL rand_align pkt %0d: align_err=%b, want %b", p, got_align, exp_align);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuffing();
    test_stuff_error();
    test_align();
    test_eop_collision();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
